mem_arbiter: RTL and testbench

- Shares one unified, variable-latency memory port between the hart's instruction-fetch requester and its data-memory (load/store) requester.
- Sits between the fetch and memory-access stages and the backing memory. It replaces the idealised, separate, combinational imem and dmem ports.
- Keeps one transaction outstanding at a time. Data requests have priority, with a starvation guard for fetch and a kill input for squashed fetches.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/arb_prio.sv | 48 ++++
 rtl/mem_arbiter.sv | 150 +++++++++++++++
 tb/tb_mem_arbiter.sv | 458 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified instruction/data memory arbiter.
package mem_arb_pkg;

    // Default number of back-to-back data grants tolerated while fetch waits.
    localparam int unsigned STARVE_LIMIT_DEF = 4;
    localparam int unsigned CNT_W_DEF        = 3;

    // Byte-lane mask used for every instruction fetch.
    localparam logic [3:0] MaskAll = 4'b1111;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StIssueI = 3'd1,
        StIssueD = 3'd2,
        StWaitI  = 3'd3,
        StWaitD  = 3'd4,
        StAckD   = 3'd5
    } arb_state_e;

endpackage

// File: rtl/arb_prio.sv
// Grant selection between fetch and data requesters with a fetch starvation guard.
module arb_prio
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int unsigned CNT_W        = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic idle,
    input  logic imem_req,
    input  logic dmem_req,
    output logic grant_i,
    output logic grant_d
);

    localparam logic [CNT_W-1:0] Limit = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fetch_forced;

    // Data normally wins; fetch is forced through once the guard count is reached.
    always_comb begin
        fetch_forced = (STARVE_LIMIT != 0) && imem_req && (cnt_q == Limit);
        grant_d      = idle && dmem_req && !fetch_forced;
        grant_i      = idle && imem_req && !grant_d;
    end

    // Count data grants that overtook a waiting fetch, saturating at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (grant_i) begin
            cnt_d = '0;
        end else if (grant_d && imem_req && (cnt_q != Limit)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one variable-latency memory port between instruction fetch and data access,
// one transaction outstanding at a time.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int unsigned CNT_W        = CNT_W_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_imem_req,
    input  logic [31:0] i_imem_addr,
    input  logic        i_imem_kill,
    output logic        o_imem_ready,
    output logic        o_imem_valid,
    output logic [31:0] o_imem_rdata,
    input  logic        i_dmem_req,
    input  logic [31:0] i_dmem_addr,
    input  logic        i_dmem_ren,
    input  logic        i_dmem_wen,
    input  logic [31:0] i_dmem_wdata,
    input  logic [3:0]  i_dmem_mask,
    output logic        o_dmem_ready,
    output logic        o_dmem_valid,
    output logic [31:0] o_dmem_rdata,
    output logic        o_mem_req,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_wen,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_mask,
    input  logic        i_mem_ready,
    input  logic        i_mem_valid,
    input  logic [31:0] i_mem_rdata
);

    arb_state_e  state_q, state_d;
    logic        drop_q, drop_d;
    logic [31:0] addr_q, wdata_q;
    logic        wen_q;
    logic [3:0]  mask_q;
    logic        idle, grant_i, grant_d;

    // Gating with rst_n keeps the ready outputs low while reset is asserted.
    assign idle = (state_q == StIdle) && rst_n;

    arb_prio #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) u_prio (
        .clk      (clk),
        .rst_n    (rst_n),
        .idle     (idle),
        .imem_req (i_imem_req),
        .dmem_req (i_dmem_req),
        .grant_i  (grant_i),
        .grant_d  (grant_d)
    );

    assign o_imem_ready = grant_i;
    assign o_dmem_ready = grant_d;
    assign o_mem_addr   = addr_q;
    assign o_mem_wen    = wen_q;
    assign o_mem_wdata  = wdata_q;
    assign o_mem_mask   = mask_q;

    // Next-state, kill tracking and response steering.
    always_comb begin
        state_d      = state_q;
        drop_d       = drop_q;
        o_mem_req    = 1'b0;
        o_imem_valid = 1'b0;
        o_imem_rdata = '0;
        o_dmem_valid = 1'b0;
        o_dmem_rdata = '0;
        unique case (state_q)
            StIdle: begin
                if (grant_d) begin
                    // A request with neither read nor write is acknowledged without a memory access.
                    state_d = (i_dmem_ren || i_dmem_wen) ? StIssueD : StAckD;
                end else if (grant_i) begin
                    state_d = StIssueI;
                end
            end
            StIssueI: begin
                o_mem_req = 1'b1;
                if (i_imem_kill) drop_d = 1'b1;
                if (i_mem_ready) state_d = StWaitI;
            end
            StIssueD: begin
                o_mem_req = 1'b1;
                if (i_mem_ready) state_d = StWaitD;
            end
            StWaitI: begin
                if (i_imem_kill) drop_d = 1'b1;
                if (i_mem_valid) begin
                    // The memory transaction always completes; a kill only hides the pulse.
                    o_imem_valid = !drop_q;
                    o_imem_rdata = i_mem_rdata;
                    drop_d       = 1'b0;
                    state_d      = StIdle;
                end
            end
            StWaitD: begin
                if (i_mem_valid) begin
                    o_dmem_valid = 1'b1;
                    o_dmem_rdata = wen_q ? 32'h0 : i_mem_rdata;
                    state_d      = StIdle;
                end
            end
            StAckD: begin
                o_dmem_valid = 1'b1;
                state_d      = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM state and drop flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
        end
    end

    // Capture the winning requester's payload on the grant cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            mask_q  <= '0;
        end else if (grant_i) begin
            addr_q <= i_imem_addr;
            wen_q  <= 1'b0;
            mask_q <= MaskAll;
        end else if (grant_d) begin
            addr_q  <= i_dmem_addr;
            wen_q   <= i_dmem_wen;
            wdata_q <= i_dmem_wdata;
            mask_q  <= i_dmem_mask;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: grant-time predictions are queued, a response
// monitor pops them when the memory answers, a behavioural memory backs the port.
module tb_mem_arbiter;

    localparam int unsigned SL = 2;

    typedef struct packed {
        bit        is_fetch;
        bit        is_null;
        bit        killed;
        bit [31:0] data;
        int        acc;
    } exp_t;

    typedef struct packed {
        bit [31:0] addr;
        bit        wen;
        bit [31:0] wdata;
        bit [3:0]  mask;
    } mreq_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req, imem_kill, dmem_req, dmem_ren, dmem_wen;
    logic [31:0] imem_addr, dmem_addr, dmem_wdata;
    logic [3:0]  dmem_mask;
    logic        mem_ready = 1'b0, mem_valid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        o_imem_ready, o_imem_valid, o_dmem_ready, o_dmem_valid;
    logic [31:0] o_imem_rdata, o_dmem_rdata;
    logic        o_mem_req, o_mem_wen;
    logic [31:0] o_mem_addr, o_mem_wdata;
    logic [3:0]  o_mem_mask;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rsp_cyc = -1;
    int starve  = 0;
    int iv_pulses = 0;
    int dv_pulses = 0;

    exp_t  exp_q[$];
    mreq_t exp_mem[$];
    byte   grant_log[$];
    bit [31:0] ref_mem  [bit [31:0]];
    bit [31:0] back_mem [bit [31:0]];

    bit        mem_busy = 1'b0, rsp_real = 1'b0, rsp_stale = 1'b0;
    bit        mem_mode = 1'b1, spur_en = 1'b0, rand_done = 1'b0;
    int        mem_delay = 0, fixed_delay = 2;
    bit [31:0] mem_rsp = 32'h0;

    mem_arbiter #(
        .STARVE_LIMIT (SL),
        .CNT_W        (3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_imem_req   (imem_req),
        .i_imem_addr  (imem_addr),
        .i_imem_kill  (imem_kill),
        .o_imem_ready (o_imem_ready),
        .o_imem_valid (o_imem_valid),
        .o_imem_rdata (o_imem_rdata),
        .i_dmem_req   (dmem_req),
        .i_dmem_addr  (dmem_addr),
        .i_dmem_ren   (dmem_ren),
        .i_dmem_wen   (dmem_wen),
        .i_dmem_wdata (dmem_wdata),
        .i_dmem_mask  (dmem_mask),
        .o_dmem_ready (o_dmem_ready),
        .o_dmem_valid (o_dmem_valid),
        .o_dmem_rdata (o_dmem_rdata),
        .o_mem_req    (o_mem_req),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wen    (o_mem_wen),
        .o_mem_wdata  (o_mem_wdata),
        .o_mem_mask   (o_mem_mask),
        .i_mem_ready  (mem_ready),
        .i_mem_valid  (mem_valid),
        .i_mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    function automatic bit [31:0] init_word(input bit [31:0] a);
        return (a * 32'h0001_0003) ^ 32'h5A5A_A5A5;
    endfunction

    function automatic bit [31:0] ref_rd(input bit [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_word(a);
    endfunction

    function automatic bit [31:0] back_rd(input bit [31:0] a);
        if (back_mem.exists(a)) return back_mem[a];
        return init_word(a);
    endfunction

    function automatic bit [31:0] merge(input bit [31:0] old, input bit [31:0] nw,
                                        input bit [3:0] m);
        bit [31:0] r = old;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // Behavioural memory: drives ready/valid just after each rising edge.
    initial forever begin
        @(posedge clk);
        #1;
        if (mem_busy) begin
            mem_ready = 1'b0;
            if (mem_delay <= 1) begin
                mem_valid = 1'b1;
                mem_rdata = mem_rsp;
                rsp_real  = 1'b1;
                mem_busy  = 1'b0;
            end else begin
                mem_delay--;
                mem_valid = 1'b0;
                rsp_real  = 1'b0;
                mem_rdata = $urandom;
            end
        end else begin
            rsp_real  = 1'b0;
            mem_valid = spur_en && ($urandom_range(0, 7) == 0);
            mem_rdata = $urandom;
            mem_ready = mem_mode ? 1'b1 : ($urandom_range(0, 3) != 0);
        end
    end

    // Reset discards all predictions; an in-flight memory answer becomes stale.
    initial forever begin
        @(negedge rst_n);
        exp_q.delete();
        exp_mem.delete();
        starve    = 0;
        rsp_cyc   = -1;
        rsp_stale = mem_busy;
    end

    // Response monitor: pops the prediction when the memory answers and checks the pulses.
    initial forever begin
        exp_t h;
        bit ei, ed;
        bit [31:0] er;
        @(negedge clk);
        if (rst_n) begin
            ei = 1'b0;
            ed = 1'b0;
            er = 32'h0;
            if (exp_q.size() > 0) begin
                h = exp_q[0];
                if (h.is_null) begin
                    if (cyc == h.acc + 1) begin
                        ed = 1'b1;
                        void'(exp_q.pop_front());
                        rsp_cyc = cyc;
                    end
                end else if (mem_valid && rsp_real && !rsp_stale) begin
                    void'(exp_q.pop_front());
                    rsp_cyc = cyc;
                    er = h.data;
                    if (h.is_fetch) ei = !h.killed;
                    else ed = 1'b1;
                end
            end
            check("imem_valid", o_imem_valid, ei);
            check("dmem_valid", o_dmem_valid, ed);
            if (ei) check("imem_rdata", o_imem_rdata, er);
            if (ed) check("dmem_rdata", o_dmem_rdata, er);
            if (o_imem_valid) iv_pulses++;
            if (o_dmem_valid) dv_pulses++;
            if (imem_kill && exp_q.size() > 0 && exp_q[0].is_fetch && cyc > exp_q[0].acc) begin
                h = exp_q[0];
                h.killed = 1'b1;
                exp_q[0] = h;
            end
        end
    end

    // Issue model: predicts grants, queues expectations, checks the memory request payload.
    initial forever begin
        bit idle_m, gi, gd;
        mreq_t m;
        exp_t e;
        @(negedge clk);
        #2;
        if (rst_n) begin
            idle_m = (exp_q.size() == 0) && (rsp_cyc != cyc);
            gi = 1'b0;
            gd = 1'b0;
            if (idle_m) begin
                if (dmem_req && !(imem_req && SL != 0 && starve == int'(SL))) gd = 1'b1;
                else if (imem_req) gi = 1'b1;
            end
            check("imem_ready", o_imem_ready, gi);
            check("dmem_ready", o_dmem_ready, gd);
            check("mem_req", o_mem_req, exp_mem.size() != 0);
            if (o_mem_req && mem_ready && !mem_busy && exp_mem.size() > 0) begin
                m = exp_mem.pop_front();
                check("mem_addr", o_mem_addr, m.addr);
                check("mem_wen", o_mem_wen, m.wen);
                check("mem_mask", o_mem_mask, m.mask);
                if (m.wen) check("mem_wdata", o_mem_wdata, m.wdata);
                if (o_mem_wen) begin
                    back_mem[o_mem_addr] = merge(back_rd(o_mem_addr), o_mem_wdata, o_mem_mask);
                    mem_rsp = $urandom;
                end else begin
                    mem_rsp = back_rd(o_mem_addr);
                end
                mem_busy  = 1'b1;
                rsp_stale = 1'b0;
                mem_delay = mem_mode ? fixed_delay : int'($urandom_range(1, 3));
            end
            if (gd) begin
                grant_log.push_back("D");
                if (imem_req && starve < int'(SL)) starve++;
                e = '{is_fetch: 1'b0, is_null: 1'b0, killed: 1'b0, data: 32'h0, acc: cyc};
                if (!dmem_ren && !dmem_wen) begin
                    e.is_null = 1'b1;
                end else begin
                    if (dmem_wen) ref_mem[dmem_addr] = merge(ref_rd(dmem_addr), dmem_wdata, dmem_mask);
                    else e.data = ref_rd(dmem_addr);
                    exp_mem.push_back('{addr: dmem_addr, wen: dmem_wen, wdata: dmem_wdata,
                                        mask: dmem_mask});
                end
                exp_q.push_back(e);
            end else if (gi) begin
                grant_log.push_back("I");
                starve = 0;
                exp_q.push_back('{is_fetch: 1'b1, is_null: 1'b0, killed: 1'b0,
                                  data: ref_rd(imem_addr), acc: cyc});
                exp_mem.push_back('{addr: imem_addr, wen: 1'b0, wdata: 32'h0, mask: 4'b1111});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input logic [31:0] a);
        int n = 0;
        bit got = 1'b0;
        imem_req  = 1'b1;
        imem_addr = a;
        while (!got && n < 400) begin
            @(negedge clk);
            if (rst_n && o_imem_ready) got = 1'b1;
            n++;
        end
        if (!got) check("fetch_accept_timeout", got, 1);
        step();
        imem_req  = 1'b0;
        imem_addr = $urandom;
    endtask

    task automatic do_data(input logic [31:0] a, input logic r, input logic w,
                           input logic [31:0] wd, input logic [3:0] m);
        int n = 0;
        bit got = 1'b0;
        dmem_req = 1'b1;
        dmem_addr = a;
        dmem_ren = r;
        dmem_wen = w;
        dmem_wdata = wd;
        dmem_mask = m;
        while (!got && n < 400) begin
            @(negedge clk);
            if (rst_n && o_dmem_ready) got = 1'b1;
            n++;
        end
        if (!got) check("data_accept_timeout", got, 1);
        step();
        dmem_req = 1'b0;
        dmem_addr = $urandom;
        dmem_wdata = $urandom;
    endtask

    task automatic wait_quiet();
        int n = 0;
        bit ok = 1'b0;
        while (!ok && n < 400) begin
            @(negedge clk);
            ok = (exp_q.size() == 0) && (exp_mem.size() == 0) && !mem_busy;
            n++;
        end
        check("quiet_timeout", ok, 1);
        step();
        step();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_imem_ready"}, o_imem_ready, 0);
        check({tag, "_imem_valid"}, o_imem_valid, 0);
        check({tag, "_dmem_ready"}, o_dmem_ready, 0);
        check({tag, "_dmem_valid"}, o_dmem_valid, 0);
        check({tag, "_dmem_rdata"}, o_dmem_rdata, 0);
        check({tag, "_mem_req"}, o_mem_req, 0);
        check({tag, "_mem_addr"}, o_mem_addr, 0);
        check({tag, "_mem_wen"}, o_mem_wen, 0);
        check({tag, "_mem_wdata"}, o_mem_wdata, 0);
        check({tag, "_mem_mask"}, o_mem_mask, 0);
    endtask

    task automatic check_order(input string name, input string want);
        check({name, "_count"}, grant_log.size(), want.len());
        for (int i = 0; i < want.len() && i < grant_log.size(); i++)
            check(name, grant_log[i], want[i]);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int iv0, dv0;
        rst_n = 1'b0;
        imem_req = 1'b0; imem_addr = 32'h0; imem_kill = 1'b0;
        dmem_req = 1'b0; dmem_addr = 32'h0; dmem_ren = 1'b0; dmem_wen = 1'b0;
        dmem_wdata = 32'h0; dmem_mask = 4'h0;
        step();
        step();
        check_zero("reset");
        rst_n = 1'b1;
        step();

        // Lone fetch with an immediate-ready memory answering two cycles after accept.
        ref_mem[32'h10]  = 32'h0050_0093;
        back_mem[32'h10] = 32'h0050_0093;
        iv0 = iv_pulses;
        do_fetch(32'h10);
        wait_quiet();
        check("lone_fetch_pulses", iv_pulses - iv0, 1);

        // Simultaneous requests: byte-lane write goes first, then the fetch.
        grant_log.delete();
        fork
            do_data(32'h2000, 1'b0, 1'b1, 32'hAB00_0000, 4'b1000);
            do_fetch(32'h10);
        join
        wait_quiet();
        check_order("simul_order", "DI");
        do_data(32'h2000, 1'b1, 1'b0, 32'h0, 4'b1111);
        wait_quiet();

        // Starvation guard with limit 2; the second fetch shows the counter restarted.
        grant_log.delete();
        fork
            begin
                do_fetch(32'h1004);
                do_fetch(32'h1008);
            end
            begin
                do_data(32'h1000, 1'b0, 1'b1, 32'h1111_2222, 4'b1111);
                do_data(32'h1004, 1'b1, 1'b0, 32'h0, 4'b1111);
                do_data(32'h1008, 1'b0, 1'b1, 32'h3333_4444, 4'b0011);
                do_data(32'h1000, 1'b1, 1'b0, 32'h0, 4'b1111);
            end
        join
        wait_quiet();
        check_order("starve_order", "DDIDDI");

        // Kill while the fetch waits for memory: pulse suppressed, next fetch delivered.
        fixed_delay = 3;
        iv0 = iv_pulses;
        do_fetch(32'h10);
        step();
        imem_kill = 1'b1;
        step();
        imem_kill = 1'b0;
        wait_quiet();
        check("kill_suppressed", iv_pulses - iv0, 0);
        do_fetch(32'h14);
        wait_quiet();
        check("after_kill_delivered", iv_pulses - iv0, 1);

        // Null data request is acknowledged without touching memory.
        dv0 = dv_pulses;
        do_data(32'h3000, 1'b0, 1'b0, 32'hDEAD_BEEF, 4'b1111);
        wait_quiet();
        check("null_ack_pulses", dv_pulses - dv0, 1);

        // Reset while a read waits; the late memory answer must not surface.
        dv0 = dv_pulses;
        do_data(32'h1000, 1'b1, 1'b0, 32'h0, 4'b1111);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("midreset");
        step();
        rst_n = 1'b1;
        repeat (5) step();
        check("late_valid_ignored", dv_pulses - dv0, 0);
        do_data(32'h1000, 1'b1, 1'b0, 32'h0, 4'b1111);
        wait_quiet();
        check("post_reset_served", dv_pulses - dv0, 1);

        // Randomised traffic with random ready/latency, spurious valids and kills.
        mem_mode = 1'b0;
        spur_en  = 1'b1;
        fork
            begin
                fork
                    begin
                        for (int k = 0; k < 40; k++) begin
                            repeat ($urandom_range(0, 3)) step();
                            do_fetch(32'h1000 + 32'(4 * $urandom_range(0, 15)));
                        end
                    end
                    begin
                        for (int k = 0; k < 40; k++) begin
                            int op;
                            repeat ($urandom_range(0, 3)) step();
                            op = int'($urandom_range(0, 3));
                            do_data(32'h1000 + 32'(4 * $urandom_range(0, 15)),
                                    (op == 1) || (op == 3), op >= 2, $urandom,
                                    4'($urandom_range(0, 15)));
                        end
                    end
                join
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    step();
                    imem_kill = ($urandom_range(0, 5) == 0);
                end
                imem_kill = 1'b0;
            end
        join
        spur_en = 1'b0;
        wait_quiet();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
